// File: rtl/doc_pkg.sv
// Shared definitions for the document export path: field widths, ASCII codes, sender states.
package doc_pkg;

  localparam int unsigned DOC_ROW_W  = 4;
  localparam int unsigned DOC_COL_W  = 5;
  localparam int unsigned DOC_ADDR_W = 10;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StWait,
    StCr,
    StLf,
    StFin
  } sender_state_e;

  function automatic logic [DOC_ADDR_W-1:0] doc_addr(input logic [DOC_ROW_W-1:0] row,
                                                     input logic [DOC_COL_W-1:0] col);
    return {1'b0, row, col};
  endfunction

  // Empty document cells read back as NUL; export them as spaces.
  function automatic logic [7:0] map_char(input logic [7:0] c);
    return (c == 8'h00) ? ASCII_SP : c;
  endfunction

endpackage

// File: rtl/uart_doc_sender_if.sv
// Document RAM spare-port bundle: address/enable from the exporter, async read data back.
interface uart_doc_sender_if ();

  logic                            read_enable;
  logic [doc_pkg::DOC_ADDR_W-1:0]  read_addr;
  logic [7:0]                      read_data;

  modport master (output read_enable, output read_addr, input read_data);
  modport slave  (input read_enable, input read_addr, output read_data);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned     BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  logic [BaudW-1:0] baud_q;
  logic [3:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;

  // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (tx_start) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= tx_byte;
      tx_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (baud_q == BaudLast) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
          bit_q  <= '0;
        end else begin
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            tx_q <= 1'b1;
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end
        end
      end else begin
        baud_q <= baud_q + BaudW'(1);
      end
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = busy_q && (bit_q == 4'd9) && (baud_q == BaudLast);

endmodule

// File: rtl/uart_doc_sender.sv
// Streams the document RAM row-major over UART, appending CR LF after each row, on a start pulse.
module uart_doc_sender
  import doc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ROWS   = 15,
  parameter int unsigned COLS   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  uart_doc_sender_if.master  doc,
  output logic               busy,
  output logic               done,
  output logic               tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [DOC_ROW_W-1:0] RowLast = DOC_ROW_W'(ROWS - 1);
  localparam logic [DOC_COL_W-1:0] ColLast = DOC_COL_W'(COLS - 1);

  sender_state_e           state_q;
  logic [DOC_ROW_W-1:0]    row_q;
  logic [DOC_COL_W-1:0]    col_q;
  logic [1:0]              phase_q;
  logic [7:0]              byte_q;
  logic                    tx_start_q;
  logic                    read_enable_q;
  logic [DOC_ADDR_W-1:0]   read_addr_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    tx_busy;
  logic                    tx_done;

  // CR/LF reuse the FETCH/SEND/WAIT cadence via phase_q so every inter-frame gap is identical.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      row_q         <= '0;
      col_q         <= '0;
      phase_q       <= '0;
      byte_q        <= '0;
      tx_start_q    <= 1'b0;
      read_enable_q <= 1'b0;
      read_addr_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      tx_start_q    <= 1'b0;
      read_enable_q <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StFetch;
            row_q         <= '0;
            col_q         <= '0;
            busy_q        <= 1'b1;
            read_enable_q <= 1'b1;
            read_addr_q   <= doc_addr('0, '0);
          end
        end
        StFetch: begin
          byte_q  <= map_char(doc.read_data);
          state_q <= StSend;
        end
        StSend: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (tx_done) begin
            if (col_q == ColLast) begin
              col_q   <= '0;
              phase_q <= '0;
              state_q <= StCr;
            end else begin
              col_q         <= col_q + DOC_COL_W'(1);
              state_q       <= StFetch;
              read_enable_q <= 1'b1;
              read_addr_q   <= doc_addr(row_q, col_q + DOC_COL_W'(1));
            end
          end
        end
        StCr, StLf: begin
          unique case (phase_q)
            2'd0: begin
              byte_q  <= (state_q == StCr) ? ASCII_CR : ASCII_LF;
              phase_q <= 2'd1;
            end
            2'd1: begin
              if (!tx_busy) begin
                tx_start_q <= 1'b1;
                phase_q    <= 2'd2;
              end
            end
            2'd2: begin
              if (tx_done) begin
                phase_q <= '0;
                if (state_q == StCr) begin
                  state_q <= StLf;
                end else if (row_q == RowLast) begin
                  state_q <= StFin;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                end else begin
                  row_q         <= row_q + DOC_ROW_W'(1);
                  state_q       <= StFetch;
                  read_enable_q <= 1'b1;
                  read_addr_q   <= doc_addr(row_q + DOC_ROW_W'(1), '0);
                end
              end
            end
            default: phase_q <= '0;
          endcase
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start_q),
    .tx_byte  (byte_q),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  assign doc.read_enable = read_enable_q;
  assign doc.read_addr   = read_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_uart_doc_sender.sv
// Scoreboard bench: expected UART frames and read addresses queued by stimulus, checked by monitors.
module tb_uart_doc_sender;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, tx;

  logic [7:0] mem [0:1023];

  uart_doc_sender_if doc_if ();

  assign doc_if.read_data = mem[doc_if.read_addr];

  uart_doc_sender #(
    .CLK_HZ (1_000_000),
    .BAUD   (100_000),
    .ROWS   (2),
    .COLS   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .doc   (doc_if),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_bytes [$];
  logic [9:0] exp_addrs [$];
  int re_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench's own model of the export: row-major bytes with NUL->space, then CR LF per row.
  task automatic push_export();
    logic [7:0] c;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        c = mem[r * 32 + k];
        exp_bytes.push_back((c == 8'h00) ? 8'h20 : c);
        exp_addrs.push_back(10'(r * 32 + k));
      end
      exp_bytes.push_back(8'h0D);
      exp_bytes.push_back(8'h0A);
    end
  endtask

  always @(negedge clk) begin
    if (doc_if.read_enable) re_cnt++;
    if (done) done_cnt++;
    if (rst_n && dut.tx_start_q && dut.tx_busy) begin
      failures++;
      $display("FAIL tx_start_while_busy: got 1 expected 0");
    end
  end

  // Address monitor
  always @(negedge clk) begin
    if (rst_n && doc_if.read_enable) begin
      checks++;
      if (exp_addrs.size() == 0) begin
        failures++;
        $display("FAIL read_addr: got %0d expected none", doc_if.read_addr);
      end else if (doc_if.read_addr !== exp_addrs[0]) begin
        failures++;
        $display("FAIL read_addr: got %0d expected %0d", doc_if.read_addr, exp_addrs[0]);
        void'(exp_addrs.pop_front());
      end else begin
        void'(exp_addrs.pop_front());
      end
    end
  end

  // UART monitor: sample mid-bit, compare whole frame {stop, data, start}
  initial begin
    logic [9:0] bits;
    logic [7:0] eb;
    bit aborted;
    int n;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        aborted = 1'b0;
        bits = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          n = (b == 0) ? 4 : 10;
          for (int k = 0; k < n && !aborted; k++) begin
            @(negedge clk);
            if (!rst_n) aborted = 1'b1;
          end
          bits[b] = tx;
        end
        if (!aborted) begin
          checks++;
          if (exp_bytes.size() == 0) begin
            failures++;
            $display("FAIL uart_frame: got %03h expected none", bits);
          end else begin
            eb = exp_bytes.pop_front();
            if (bits !== {1'b1, eb, 1'b0}) begin
              failures++;
              $display("FAIL uart_frame: got %03h expected %03h", bits, {1'b1, eb, 1'b0});
            end
          end
        end
      end
    end
  end

  task automatic run_export(input string tag, input int hold, input bit repulse);
    int cyc;
    int fall;
    push_export();
    re_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (hold == 0) start = 1'b0;
    cyc = 0;
    fall = -1;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) start = 1'b0;
      if (repulse && cyc == 500) start = 1'b1;
      if (repulse && cyc == 501) start = 1'b0;
      if (fall < 0 && tx == 1'b0) fall = cyc;
    end
    check({tag, "_first_start_bit_latency"}, 32'(fall), 32'd3);
    check({tag, "_start_to_done_cycles"}, 32'(cyc), 32'd1030);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
    check({tag, "_addrs_left"}, 32'(exp_addrs.size()), 32'd0);
    check({tag, "_read_enable_cycles"}, 32'(re_cnt), 32'd6);
    check({tag, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_read_enable", 32'(doc_if.read_enable), 32'd0);
    check("reset_read_addr", 32'(doc_if.read_addr), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // row0 = "ABC", row1 = NUL 'x' NUL
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43;
    mem[32] = 8'h00; mem[33] = 8'h78; mem[34] = 8'h00;
    run_export("abc", 0, 1'b0);

    // alternating 0x55 pattern
    mem[0] = 8'h55; mem[1] = 8'h55; mem[2] = 8'h55;
    run_export("x55", 0, 1'b0);

    // start held for 20 cycles, then pulsed again mid-export
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43;
    run_export("held", 20, 1'b1);

    // reset during data bit 1 of 'A' (a 0 bit)
    push_export();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    check("pre_reset_tx_low", 32'(tx), 32'd0);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    exp_bytes.delete();
    exp_addrs.delete();
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_read_enable", 32'(doc_if.read_enable), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_export("after_reset", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
